// File: rtl/cpc_ram_bank_ctrl.sv
// Bank controller for the CPC 512K RAM expansion: snoops gate-array config writes, maps 16K
// blocks onto external SRAM pages and sequences CS/OE/WE. Optional CPC_RAM_WAIT_EN adds one wait state.
module cpc_ram_bank_ctrl #(
  parameter int BANK_BITS = 3,
  parameter int WE_SETUP  = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_b_i,
  input  logic                 a15_i,
  input  logic                 a14_i,
  input  logic [7:0]           d_i,
  input  logic                 mreq_b_i,
  input  logic                 ioreq_b_i,
  input  logic                 rd_b_i,
  input  logic                 wr_b_i,
  input  logic                 rfsh_b_i,
  input  logic                 ramrd_b_i,
  output logic [BANK_BITS+1:0] hiadr_o,
  output logic                 ramcs_b_o,
  output logic                 ramoe_b_o,
  output logic                 ramwe_b_o,
  output logic                 ramdis_o,
  output logic                 ready_o
);

  localparam int CW = (WE_SETUP > 1) ? $clog2(WE_SETUP) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WSET, S_WPUL, S_WEND} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             cfg_q;
  logic [BANK_BITS-1:0]   bank_q;
  logic                   iowr, iowr_q;
  logic                   armed_q, armed_d;
  logic [BANK_BITS+1:0]   hiadr_q, hiadr_d;
  logic                   cs_q, oe_q, we_q;
  logic [1:0]             blk, ext_blk;
  logic                   ext_hit, mem_rd, mem_wr, start;
  logic                   unused_rd_b;

  // The Z80 RD_B strobe is redundant here: the gate array's RAMRD_B already qualifies RAM reads.
  assign unused_rd_b = rd_b_i;

  assign iowr   = !ioreq_b_i && !wr_b_i && !a15_i && (d_i[7:6] == 2'b11);
  assign mem_rd = !mreq_b_i && !ramrd_b_i && rfsh_b_i;
  assign mem_wr = !mreq_b_i && !wr_b_i && rfsh_b_i;
  assign blk    = {a15_i, a14_i};

  always_comb begin
    ext_hit = 1'b0;
    ext_blk = 2'd3;
    case (cfg_q)
      3'd0: ext_hit = 1'b0;
      3'd1,
      3'd3: ext_hit = (blk == 2'd3);
      3'd2: begin ext_hit = 1'b1; ext_blk = blk; end
      default: begin ext_hit = (blk == 2'd1); ext_blk = cfg_q[1:0]; end
    endcase
  end

  assign ramdis_o = ext_hit && !mreq_b_i && rfsh_b_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (armed_q && ext_hit) begin
          if (mem_rd)      state_d = S_RD;
          else if (mem_wr) state_d = S_WSET;
        end
      end
      S_RD:   if (mreq_b_i) state_d = S_IDLE;
      S_WSET: begin
        if (mreq_b_i)                      state_d = S_IDLE;
        else if (cnt_q == CW'(WE_SETUP-1)) state_d = S_WPUL;
        else                               cnt_d   = cnt_q + 1'b1;
      end
      S_WPUL: if (wr_b_i || mreq_b_i) state_d = S_WEND;
      S_WEND: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign start = (state_q == S_IDLE) && (state_d != S_IDLE);

  // One access per MREQ cycle: re-arm only after MREQ_B is seen high at an edge.
  always_comb begin
    armed_d = armed_q;
    if (mreq_b_i)   armed_d = 1'b1;
    else if (start) armed_d = 1'b0;
  end

  assign hiadr_d = start ? {bank_q, ext_blk} : hiadr_q;

  always_ff @(posedge clk_i) begin
    if (!reset_b_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cfg_q   <= '0;
      bank_q  <= '0;
      iowr_q  <= 1'b0;
      armed_q <= 1'b0;
      hiadr_q <= '0;
      cs_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iowr_q  <= iowr;
      armed_q <= armed_d;
      hiadr_q <= hiadr_d;
      if (iowr && !iowr_q) begin
        bank_q <= d_i[3 +: BANK_BITS];
        cfg_q  <= d_i[2:0];
      end
      // Strobes registered from next state so they change cleanly on the edge.
      cs_q <= (state_d == S_IDLE);
      oe_q <= (state_d != S_RD);
      we_q <= (state_d != S_WPUL);
    end
  end

  assign hiadr_o   = hiadr_q;
  assign ramcs_b_o = cs_q;
  assign ramoe_b_o = oe_q;
  assign ramwe_b_o = we_q;

`ifdef CPC_RAM_WAIT_EN
  logic ready_q;
  always_ff @(posedge clk_i) begin
    if (!reset_b_i) ready_q <= 1'b1;
    else            ready_q <= !start;
  end
  assign ready_o = ready_q;
`else
  assign ready_o = 1'b1;
`endif

endmodule
